lfsr_rng_arbiter: RTL and testbench

- Shares one embedded Fibonacci LFSR random source among NREQ requesters.
- Round-robin grant; per grant, shifts exactly OUT_WIDTH fresh bits (XOR-mixed with an external entropy bit), then hands them to the granted requester with a one-cycle ack.
- Bits are never reused between requesters.
- Supports runtime reseeding and all-zero lockup recovery.
- Sits between on-chip consumers (scramblers, dither, test pattern units) and the entropy source.

---
 rtl/lfsr_rng_arbiter.sv | 133 +++++++++++++
 tb/tb_lfsr_rng_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter sharing one Fibonacci LFSR among NREQ requesters.
// Ports: clk, rst_n, entropy, req/ack/data, seed_valid/seed, busy, lockup.
module lfsr_rng_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = 16'hACE1,
  parameter logic [WIDTH-1:0] FEEDBACK = 16'h002D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 entropy,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      ack,
  output logic [OUT_WIDTH-1:0] data,
  input  logic                 seed_valid,
  input  logic [WIDTH-1:0]     seed,
  output logic                 busy,
  output logic                 lockup
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(OUT_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DELIVER
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     sr_q, sr_d;
  logic                 lockup_q, lockup_d;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        gidx_q;
  logic [NREQ-1:0]      ack_q;
  logic [OUT_WIDTH-1:0] data_q;
  logic                 busy_q;

  logic                 fb;
  logic [WIDTH-1:0]     seed_fix;
  logic                 gnt_ok;
  logic [IW-1:0]        gnt_idx;
  int                   j;

  assign fb = entropy ^ (^(sr_q & FEEDBACK));
  // A zero seed would lock the LFSR, so it maps to the init state.
  assign seed_fix = (seed == '0) ? INIT_VALUE : seed;

  // Seed beats lockup repair, which beats the normal FILL shift.
  always_comb begin
    sr_d = sr_q;
    lockup_d = 1'b0;
    if (seed_valid) begin
      sr_d = seed_fix;
    end else if (sr_q == '0) begin
      sr_d = INIT_VALUE;
      lockup_d = 1'b1;
    end else if (state_q == FILL) begin
      sr_d = {fb, sr_q[WIDTH-1:1]};
    end
  end

  // First set request after the pointer, wrapping.
  always_comb begin
    gnt_ok = 1'b0;
    gnt_idx = '0;
    j = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_ok && req[j]) begin
        gnt_ok = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr_q     <= INIT_VALUE;
      lockup_q <= 1'b0;
      cnt_q    <= '0;
      ptr_q    <= IW'(NREQ - 1);
      gidx_q   <= '0;
      ack_q    <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      lockup_q <= lockup_d;
      ack_q    <= '0;
      unique case (state_q)
        IDLE: begin
          if (gnt_ok) begin
            gidx_q  <= gnt_idx;
            ptr_q   <= gnt_idx;
            cnt_q   <= CNT_INIT;
            state_q <= FILL;
            busy_q  <= 1'b1;
          end
        end
        FILL: begin
          if (seed_valid) begin
            cnt_q <= CNT_INIT;
          end else if (cnt_q == '0) begin
            state_q <= DELIVER;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DELIVER: begin
          ack_q   <= NREQ'(1) << gidx_q;
          data_q  <= sr_q[WIDTH-1 -: OUT_WIDTH];
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack    = ack_q;
  assign data   = data_q;
  assign busy   = busy_q;
  assign lockup = lockup_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Scoreboard bench for lfsr_rng_arbiter.
// Expected grants/words are queued as driven and popped on ack.
module tb_lfsr_rng_arbiter;

  localparam logic [15:0] INIT = 16'hACE1;
  localparam logic [15:0] FB = 16'h002D;

  logic        clk;
  logic        rst_n;
  logic        entropy;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [7:0]  data;
  logic        seed_valid;
  logic [15:0] seed;
  logic        busy;
  logic        lockup;

  typedef struct {
    int         idx;
    logic [7:0] d;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk;
  int          n_err;
  logic [15:0] m_sr;
  bit          ent_rand;

  lfsr_rng_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .entropy(entropy),
    .req(req),
    .ack(ack),
    .data(data),
    .seed_valid(seed_valid),
    .seed(seed),
    .busy(busy),
    .lockup(lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s,
                                       input logic e);
    return {e ^ (^(s & FB)), s[15:1]};
  endfunction

  always @(negedge clk) begin
    if (rst_n && ack !== 4'b0) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_ack", 32'(ack), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_ack", 32'(ack), 32'(4'b1 << e.idx));
        chk("sb_data", 32'(data), 32'(e.d));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    seed_valid = 1'b0;
    entropy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_sr = INIT;
  endtask

  // Called at a negedge with the DUT idle; returns at the ack negedge.
  task automatic drive_grant(input logic [3:0] rq,
                             input logic [3:0] rq_mid,
                             input int idx,
                             input int zf_from,
                             input int seed_at,
                             input logic [15:0] sv);
    int   left;
    int   k;
    logic e;
    logic lk;
    exp_t x;
    req = rq;
    left = 8;
    k = 0;
    lk = 1'b0;
    while (left > 0) begin
      @(negedge clk);
      chk("fill_lockup", 32'(lockup), 32'(lk));
      chk("fill_ack", 32'(ack), 32'h0);
      chk("fill_busy", 32'(busy), 32'h1);
      k++;
      seed_valid = 1'b0;
      lk = 1'b0;
      if (k == 4) req = rq_mid;
      if (k == seed_at) begin
        seed_valid = 1'b1;
        seed = sv;
        m_sr = (sv == 16'h0) ? INIT : sv;
        left = 8;
      end else begin
        e = ent_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        if (zf_from != 0 && k >= zf_from) e = ^(m_sr & FB);
        entropy = e;
        if (m_sr == 16'h0) begin
          m_sr = INIT;
          lk = 1'b1;
        end else begin
          m_sr = step(m_sr, e);
        end
        left--;
      end
    end
    x.idx = idx;
    x.d = m_sr[15:8];
    sb_q.push_back(x);
    @(negedge clk);
    seed_valid = 1'b0;
    chk("dlv_lockup", 32'(lockup), 32'(lk));
    chk("dlv_ack", 32'(ack), 32'h0);
    chk("dlv_busy", 32'(busy), 32'h1);
    lk = 1'b0;
    if (m_sr == 16'h0) begin
      m_sr = INIT;
      lk = 1'b1;
    end
    @(negedge clk);
    chk("ack_time", 32'(ack), 32'(4'b1 << idx));
    chk("ack_lockup", 32'(lockup), 32'(lk));
    chk("ack_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    req = '0;
    entropy = 1'b0;
    seed_valid = 1'b0;
    seed = '0;
    ent_rand = 1'b0;
    m_sr = INIT;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_lockup", 32'(lockup), 32'h0);
    rst_n = 1'b1;

    // Single grant, no entropy: known word.
    drive_grant(4'b0001, 4'b0001, 0, 0, 0, 16'h0);
    req = '0;
    chk("first_word", 32'(data), 32'h22);
    repeat (3) @(negedge clk);
    chk("data_hold", 32'(data), 32'h22);
    chk("idle_busy", 32'(busy), 32'h0);

    // All requesting: strict rotation, back-to-back.
    do_reset();
    ent_rand = 1'b1;
    drive_grant(4'b1111, 4'b1111, 0, 0, 0, 16'h0);
    drive_grant(4'b1111, 4'b1111, 1, 0, 0, 16'h0);
    drive_grant(4'b1111, 4'b1111, 2, 0, 0, 16'h0);
    drive_grant(4'b1111, 4'b1111, 3, 0, 0, 16'h0);
    drive_grant(4'b1111, 4'b1111, 0, 0, 0, 16'h0);
    req = '0;

    // Rotation after 2, late riser waits its turn.
    do_reset();
    drive_grant(4'b0100, 4'b0100, 2, 0, 0, 16'h0);
    drive_grant(4'b1001, 4'b1011, 3, 0, 0, 16'h0);
    drive_grant(4'b0011, 4'b0011, 0, 0, 0, 16'h0);
    drive_grant(4'b0010, 4'b0010, 1, 0, 0, 16'h0);
    req = '0;

    // Zero seed in idle maps to init, no lockup.
    do_reset();
    ent_rand = 1'b0;
    seed_valid = 1'b1;
    seed = 16'h0000;
    @(negedge clk);
    seed_valid = 1'b0;
    chk("seed0_lockup", 32'(lockup), 32'h0);
    chk("seed0_busy", 32'(busy), 32'h0);
    m_sr = INIT;
    drive_grant(4'b0001, 4'b0001, 0, 0, 0, 16'h0);
    chk("seed0_word", 32'(data), 32'h22);
    // Reseed mid-fill restarts the count.
    drive_grant(4'b0001, 4'b0001, 0, 0, 3, 16'h1234);
    req = '0;

    // Forced zero state repaired inside FILL.
    do_reset();
    ent_rand = 1'b1;
    drive_grant(4'b0001, 4'b0001, 0, 5, 0, 16'h0);
    drive_grant(4'b0001, 4'b0001, 0, 1, 0, 16'h0);
    drive_grant(4'b0001, 4'b0001, 0, 1, 0, 16'h0);
    drive_grant(4'b0001, 4'b0001, 0, 0, 0, 16'h0);
    req = '0;

    // Forced zero state repaired in DELIVER.
    do_reset();
    drive_grant(4'b0010, 4'b0010, 1, 1, 0, 16'h0);
    drive_grant(4'b0010, 4'b0010, 1, 1, 0, 16'h0);
    drive_grant(4'b0010, 4'b0010, 1, 0, 0, 16'h0);
    req = '0;

    // Reset pulse mid-fill aborts the grant.
    do_reset();
    @(negedge clk);
    req = 4'b0001;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_ack", 32'(ack), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_sr = INIT;
    repeat (12) @(negedge clk);
    chk("post_rst_ack", 32'(ack), 32'h0);
    drive_grant(4'b1111, 4'b1111, 0, 0, 0, 16'h0);
    req = '0;

    repeat (3) @(negedge clk);
    chk("sb_left", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
